// File: rtl/waveform_analyzer_pkg.sv
// Shared definitions for the waveform analyzer: default sample/counter geometry,
// crossing thresholds and the measurement FSM state encoding.
package waveform_analyzer_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefCntW  = 16;
  localparam int unsigned DefMid   = 128;
  localparam int unsigned DefHyst  = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArm     = 2'd1,
    StMeasure = 2'd2
  } wa_state_e;

endpackage

// File: rtl/waveform_analyzer_hyst_comparator.sv
// Hysteresis level tracker around mid-scale; emits a combinational rise pulse
// on the accepted sample that takes the level from LOW to HIGH.
module waveform_analyzer_hyst_comparator #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Mid   = 128,
  parameter int unsigned Hyst  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_valid_i,
  input  logic [DataW-1:0] sample_i,
  input  logic             init_i,
  output logic             rise_o
);

  localparam logic [DataW-1:0] MidThr  = DataW'(Mid);
  localparam logic [DataW-1:0] RiseThr = DataW'(Mid + Hyst);
  localparam logic [DataW-1:0] FallThr = DataW'(Mid - Hyst);

  logic level_q, level_d;

  always_comb begin
    level_d = level_q;
    rise_o  = 1'b0;
    if (sample_valid_i) begin
      if (init_i) begin
        // Initial level only; a waveform that starts high is not a crossing.
        level_d = (sample_i >= MidThr);
      end else if (!level_q && (sample_i >= RiseThr)) begin
        level_d = 1'b1;
        rise_o  = 1'b1;
      end else if (level_q && (sample_i <= FallThr)) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/waveform_analyzer.sv
// Per-cycle waveform measurement: period between rising crossings, peak max/min
// and amplitude, with a sticky timeout when no crossing arrives.
module waveform_analyzer
  import waveform_analyzer_pkg::*;
#(
  parameter int unsigned DataW = DefDataW,
  parameter int unsigned CntW  = DefCntW,
  parameter int unsigned Mid   = DefMid,
  parameter int unsigned Hyst  = DefHyst
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_valid_i,
  input  logic [DataW-1:0] sample_i,
  output logic [CntW-1:0]  period_o,
  output logic [DataW-1:0] peak_max_o,
  output logic [DataW-1:0] peak_min_o,
  output logic [DataW-1:0] amplitude_o,
  output logic             meas_valid_o,
  output logic             timeout_o
);

  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  wa_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DataW-1:0] run_max_q, run_max_d;
  logic [DataW-1:0] run_min_q, run_min_d;
  logic [CntW-1:0]  period_q, period_d;
  logic [DataW-1:0] peak_max_q, peak_max_d;
  logic [DataW-1:0] peak_min_q, peak_min_d;
  logic [DataW-1:0] amp_q, amp_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;

  logic init;
  logic rise;

  waveform_analyzer_hyst_comparator #(
    .DataW (DataW),
    .Mid   (Mid),
    .Hyst  (Hyst)
  ) u_hyst_comparator (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .init_i         (init),
    .rise_o         (rise)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    period_d     = period_q;
    peak_max_d   = peak_max_q;
    peak_min_d   = peak_min_q;
    amp_d        = amp_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    init         = 1'b0;

    if (sample_valid_i) begin
      unique case (state_q)
        StIdle: begin
          init    = 1'b1;
          state_d = StArm;
        end
        StArm: begin
          if (rise) begin
            state_d   = StMeasure;
            cnt_d     = CntOne;
            run_max_d = sample_i;
            run_min_d = sample_i;
          end
        end
        StMeasure: begin
          // A rise takes priority over a saturated counter.
          if (rise) begin
            period_d     = cnt_q;
            peak_max_d   = run_max_q;
            peak_min_d   = run_min_q;
            amp_d        = run_max_q - run_min_q;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            cnt_d        = CntOne;
            run_max_d    = sample_i;
            run_min_d    = sample_i;
          end else if (cnt_q == CntMax) begin
            state_d   = StArm;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
            if (sample_i > run_max_q) run_max_d = sample_i;
            if (sample_i < run_min_q) run_min_d = sample_i;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      run_max_q    <= '0;
      run_min_q    <= '0;
      period_q     <= '0;
      peak_max_q   <= '0;
      peak_min_q   <= '0;
      amp_q        <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      period_q     <= period_d;
      peak_max_q   <= peak_max_d;
      peak_min_q   <= peak_min_d;
      amp_q        <= amp_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period_o     = period_q;
  assign peak_max_o   = peak_max_q;
  assign peak_min_o   = peak_min_q;
  assign amplitude_o  = amp_q;
  assign meas_valid_o = meas_valid_q;
  assign timeout_o    = timeout_q;

endmodule
